// File: rtl/fp16_pkg.sv
// Shared definitions for the fp16 divider writeback stage: IEEE flag bit
// positions, fp16 encoding constants and the buffered result entry layout.
package fp16_pkg;

  // Bit positions inside the 5-bit IEEE exception flag vector.
  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;

  // One buffered divider result: quotient on top, flags in the low bits.
  typedef struct packed {
    logic [15:0] q;
    logic [4:0]  flags;
  } wb_entry_t;

  localparam int WB_ENTRY_W = $bits(wb_entry_t);

  // A NaN has an all-ones exponent and a non-zero mantissa; infinities
  // (zero mantissa) do not qualify.
  function automatic logic fp16_is_nan(input logic [15:0] q);
    return (q[14:10] == FP16_EXP_MAX) && (q[9:0] != 10'h000);
  endfunction

endpackage

// File: rtl/fp16_wb_fifo.sv
// Small synchronous FIFO buffering writeback results. Occupancy is tracked
// with a counter one bit wider than the pointers so full and empty are
// unambiguous; requests that would overflow or underflow are ignored.
module fp16_wb_fifo
  import fp16_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = WB_ENTRY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          wr_en;
  logic          rd_en;

  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; emptiness is
    // defined by the counter, so stale contents are never observable.
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/fp16_div_wb.sv
// Writeback stage behind the fp16 divider: buffers results in a FIFO,
// optionally canonicalises NaN quotients, accumulates sticky IEEE flags and
// counts results delivered to the consumer.
module fp16_div_wb
  import fp16_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter bit CANON_NAN = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_q,
  input  logic [4:0]       in_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_q,
  output logic [4:0]       out_flags,
  input  logic             clr_flags,
  output logic [4:0]       flags_sticky,
  output logic [CNT_W-1:0] result_cnt
);

  wb_entry_t wr_entry;
  wb_entry_t rd_entry;
  logic      full;
  logic      empty;
  logic      push;
  logic      pop;

  // Readiness depends on occupancy alone, so a pop never frees a slot for
  // a push within the same cycle.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Build the entry to store, folding any NaN onto the canonical quiet NaN.
  always_comb begin
    // NOTE: every field gets a value on every path, so no latch can form.
    wr_entry       = '0;
    wr_entry.q     = (CANON_NAN && fp16_is_nan(in_q)) ? FP16_QNAN : in_q;
    wr_entry.flags = in_flags;
  end

  fp16_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (WB_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (full),
    .empty (empty)
  );

  // Head entry drives the outputs; an empty FIFO presents zeros.
  assign out_q     = out_valid ? rd_entry.q     : 16'h0000;
  assign out_flags = out_valid ? rd_entry.flags : 5'b00000;

  // Sticky flags: a clear wipes history first, then this cycle's push lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_sticky <= '0;
    end else if (clr_flags) begin
      flags_sticky <= push ? in_flags : 5'b00000;
    end else if (push) begin
      flags_sticky <= flags_sticky | in_flags;
    end
  end

  // Delivered-result counter, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_cnt <= '0;
    end else if (pop) begin
      result_cnt <= result_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fp16_div_wb.sv
// Scoreboard bench for fp16_div_wb. Two instances share all inputs: one with
// NaN canonicalisation and a 16-bit counter, one passing quotients unchanged
// with a 4-bit counter so the counter wrap is reachable in a short run.
module tb_fp16_div_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_q;
  logic [4:0]  in_flags;
  logic        out_ready;
  logic        clr_flags;

  logic        in_ready,  raw_in_ready;
  logic        out_valid, raw_out_valid;
  logic [15:0] out_q,     raw_out_q;
  logic [4:0]  out_flags, raw_out_flags;
  logic [4:0]  flags_sticky, raw_flags_sticky;
  logic [15:0] result_cnt;
  logic [3:0]  raw_result_cnt;

  typedef struct {
    logic [15:0] q;
    logic [15:0] raw_q;
    logic [4:0]  flags;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [4:0]  exp_sticky = '0;
  logic [15:0] exp_cnt    = '0;
  int          checks     = 0;
  int          errors     = 0;

  always #5 clk = ~clk;

  fp16_div_wb #(.DEPTH(2), .CANON_NAN(1'b1), .CNT_W(16)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_q         (in_q),
    .in_flags     (in_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_q        (out_q),
    .out_flags    (out_flags),
    .clr_flags    (clr_flags),
    .flags_sticky (flags_sticky),
    .result_cnt   (result_cnt)
  );

  fp16_div_wb #(.DEPTH(2), .CANON_NAN(1'b0), .CNT_W(4)) u_raw (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (raw_in_ready),
    .in_q         (in_q),
    .in_flags     (in_flags),
    .out_valid    (raw_out_valid),
    .out_ready    (out_ready),
    .out_q        (raw_out_q),
    .out_flags    (raw_out_flags),
    .clr_flags    (clr_flags),
    .flags_sticky (raw_flags_sticky),
    .result_cnt   (raw_result_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_canon(input logic [15:0] q);
    if (q[14:10] == 5'h1F && q[9:0] != 10'h000) return 16'h7E00;
    return q;
  endfunction

  // Monitor at the falling edge: handshakes seen here complete at the next
  // rising edge, so pops are compared and pushes recorded now.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("pop_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("out_q",      out_q,          mon_e.q);
          check("raw_out_q",  raw_out_q,      mon_e.raw_q);
          check("out_flags",  out_flags,      mon_e.flags);
          check("raw_valid",  raw_out_valid,  1'b1);
          check("cnt",        result_cnt,     exp_cnt);
          check("raw_cnt",    raw_result_cnt, exp_cnt[3:0]);
          exp_cnt = exp_cnt + 16'd1;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back('{q: model_canon(in_q), raw_q: in_q, flags: in_flags});
        exp_sticky = (clr_flags ? 5'b00000 : exp_sticky) | in_flags;
      end else if (clr_flags) begin
        exp_sticky = 5'b00000;
      end
    end
  end

  // Called shortly after a rising edge; returns shortly after the accepting edge.
  task automatic push_one(input logic [15:0] q, input logic [4:0] f, input logic clr = 1'b0);
    int n = 0;
    in_valid  = 1'b1;
    in_q      = q;
    in_flags  = f;
    clr_flags = clr;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("push_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    clr_flags = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", (sb.size() == 0), 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    exp_sticky = '0;
    exp_cnt    = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_q      = '0;
    in_flags  = '0;
    out_ready = 1'b0;
    clr_flags = 1'b0;
    #1;
    check("rst_out_valid", out_valid,    1'b0);
    check("rst_in_ready",  in_ready,     1'b1);
    check("rst_out_q",     out_q,        16'h0000);
    check("rst_out_flags", out_flags,    5'b00000);
    check("rst_sticky",    flags_sticky, 5'b00000);
    check("rst_cnt",       result_cnt,   16'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single result, one-cycle latency then popped.
    out_ready = 1'b1;
    push_one(16'h3C00, 5'b00001);
    check("single_valid", out_valid, 1'b1);
    check("single_q",     out_q,     16'h3C00);
    check("single_flags", out_flags, 5'b00001);
    @(posedge clk);
    #1;
    check("single_cnt",    result_cnt,   16'd1);
    check("single_sticky", flags_sticky, 5'b00001);
    check("single_empty",  out_valid,    1'b0);

    // Backpressure: fill, offer a third, confirm head holds.
    out_ready = 1'b0;
    push_one(16'h4000, 5'b00000);
    push_one(16'h4200, 5'b00000);
    check("full_in_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    in_q     = 16'h4400;
    in_flags = 5'b00010;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_in_ready", in_ready,  1'b0);
      check("bp_hold_q",   out_q,     16'h4000);
      check("bp_valid",    out_valid, 1'b1);
    end
    in_valid = 1'b0;
    drain();
    check("bp_cnt", result_cnt, 16'd3);

    // NaN canonicalisation versus pass-through.
    out_ready = 1'b1;
    push_one(16'hFD01, 5'b10000);
    check("nan_canon", out_q,     16'h7E00);
    check("nan_raw",   raw_out_q, 16'hFD01);
    drain();
    push_one(16'h7C00, 5'b00100);
    check("inf_kept", out_q, 16'h7C00);
    drain();
    push_one(16'h7FFF, 5'b00000);
    push_one(16'hFC00, 5'b00000);
    push_one(16'h7E00, 5'b00000);
    drain();

    // Sticky flag accumulation and clearing.
    clr_flags = 1'b1;
    @(posedge clk);
    #1;
    clr_flags = 1'b0;
    check("clr_alone", flags_sticky, 5'b00000);
    push_one(16'h3800, 5'b01000);
    push_one(16'h3400, 5'b00100);
    check("sticky_or",    flags_sticky, 5'b01100);
    check("sticky_model", flags_sticky, exp_sticky);
    push_one(16'h3000, 5'b10000, 1'b1);
    check("clr_with_push", flags_sticky, 5'b10000);
    drain();

    // Streaming from a clean reset: one result per cycle.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_q     = 16'h2000 + 16'(i);
      in_flags = 5'(i);
      @(negedge clk);
      check("stream_ready", in_ready, 1'b1);
      if (i > 0) check("stream_valid", out_valid, 1'b1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("stream_cnt",   result_cnt, 16'd10);
    check("stream_empty", out_valid,  1'b0);
    check("stream_sb",    sb.size(),  32'd0);

    // Six more pops take the 4-bit counter across its wrap.
    for (int i = 0; i < 6; i++) push_one(16'h1000 + 16'(i), 5'b00000);
    drain();
    check("cnt16",    result_cnt,     16'd16);
    check("raw_wrap", raw_result_cnt, 4'd0);

    // Reset while two entries are buffered.
    out_ready = 1'b0;
    push_one(16'h4800, 5'b01000);
    push_one(16'h4C00, 5'b00001);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid",  out_valid,     1'b0);
    check("mid_rst_raw",    raw_out_valid, 1'b0);
    check("mid_rst_sticky", flags_sticky,  5'b00000);
    check("mid_rst_cnt",    result_cnt,    16'd0);
    check("mid_rst_ready",  in_ready,      1'b1);
    sb.delete();
    exp_sticky = '0;
    exp_cnt    = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    push_one(16'h5555, 5'b00010);
    check("post_rst_q",     out_q,     16'h5555);
    check("post_rst_flags", out_flags, 5'b00010);
    drain();
    check("post_rst_cnt",    result_cnt,   16'd1);
    check("post_rst_sticky", flags_sticky, 5'b00010);
    check("post_rst_empty",  out_valid,    1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
